// File: rtl/morse_if.sv
// Keyed-line input and decoded-letter outputs of the Morse receiver.
// The master drives key; the slave (decoder) drives the results.
interface morse_if;
  logic       key;
  logic       valid;
  logic [2:0] letter;
  logic       error;
  logic [3:0] pattern;
  logic [2:0] length;
  logic       busy;

  modport master (output key, input valid, letter, error, pattern, length, busy);
  modport slave  (input key, output valid, letter, error, pattern, length, busy);
endinterface

// File: rtl/morse_decoder.sv
// Morse receiver: times marks/spaces on a synchronized key line, classifies
// dots/dashes, and decodes letters A-H into the transmitter's 3-bit code.
//   state | meaning
//   IDLE  | no letter in progress, waiting for a mark
//   MARK  | key high, timing the current mark
//   SPACE | key low after a symbol, timing the gap
module morse_decoder #(
  parameter int UNIT_CYCLES = 25_000_000
) (
  input  logic     clk,
  input  logic     reset,
  morse_if.slave   bus
);

  localparam int CW = $clog2(4*UNIT_CYCLES+1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(4*UNIT_CYCLES);
  localparam logic [CW-1:0] GLITCH_LIM = CW'(UNIT_CYCLES/2);
  localparam logic [CW-1:0] DASH_LIM   = CW'(2*UNIT_CYCLES);
  localparam logic [CW-1:0] GAP_END    = CW'(3*UNIT_CYCLES-1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  state_t        state, state_n;
  logic          sync1, key_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    sym, sym_n;
  logic [2:0]    len, len_n;
  logic          ovf, ovf_n;
  logic          emit;
  logic          match;
  logic [2:0]    code;

  logic          valid_q, error_q;
  logic [2:0]    letter_q, length_q;
  logic [3:0]    pattern_q;

  always_comb begin
    match = 1'b1;
    code  = 3'b000;
    case ({len, sym})
      7'b010_0001: code = 3'b000;
      7'b100_1000: code = 3'b001;
      7'b100_1010: code = 3'b010;
      7'b011_0100: code = 3'b011;
      7'b001_0000: code = 3'b100;
      7'b100_0010: code = 3'b101;
      7'b011_0110: code = 3'b110;
      7'b100_0000: code = 3'b111;
      default:     match = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sym_n   = sym;
    len_n   = len;
    ovf_n   = ovf;
    emit    = 1'b0;
    case (state)
      IDLE: begin
        if (key_s) begin
          state_n = MARK;
          cnt_n   = CW'(1);
        end
      end
      MARK: begin
        if (key_s) begin
          if (cnt != CNT_MAX) cnt_n = cnt + 1'b1;
        end else if (cnt < GLITCH_LIM) begin
          // A glitch is dropped; an empty letter falls straight back to idle.
          if (len != 3'd0) begin
            state_n = SPACE;
            cnt_n   = CW'(1);
          end else begin
            state_n = IDLE;
            sym_n   = 4'b0000;
            len_n   = 3'd0;
            ovf_n   = 1'b0;
          end
        end else begin
          state_n = SPACE;
          cnt_n   = CW'(1);
          if (len == 3'd4) begin
            ovf_n = 1'b1;
          end else begin
            sym_n = {sym[2:0], cnt >= DASH_LIM};
            len_n = len + 3'd1;
          end
        end
      end
      SPACE: begin
        if (key_s) begin
          state_n = MARK;
          cnt_n   = CW'(1);
        end else if (cnt == GAP_END) begin
          emit    = 1'b1;
          state_n = IDLE;
          sym_n   = 4'b0000;
          len_n   = 3'd0;
          ovf_n   = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      key_s <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      sym   <= 4'b0000;
      len   <= 3'd0;
      ovf   <= 1'b0;
    end else begin
      sync1 <= bus.key;
      key_s <= sync1;
      state <= state_n;
      cnt   <= cnt_n;
      sym   <= sym_n;
      len   <= len_n;
      ovf   <= ovf_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      letter_q  <= 3'b000;
      error_q   <= 1'b0;
      pattern_q <= 4'b0000;
      length_q  <= 3'd0;
    end else begin
      valid_q <= emit;
      if (emit) begin
        pattern_q <= sym;
        length_q  <= len;
        error_q   <= ovf | ~match;
        letter_q  <= (ovf | ~match) ? 3'b000 : code;
      end
    end
  end

  assign bus.valid   = valid_q;
  assign bus.letter  = letter_q;
  assign bus.error   = error_q;
  assign bus.pattern = pattern_q;
  assign bus.length  = length_q;
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder at UNIT_CYCLES=4: stimulus pushes expected
// letters, a monitor pops and compares on every valid pulse.
module tb_morse_decoder;

  logic clk = 1'b0;
  logic reset;
  morse_if bus();

  morse_decoder #(.UNIT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] letter;
    logic       error;
    logic [3:0] pattern;
    logic [2:0] length;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_letter(input logic [2:0] l, input logic e, input logic [3:0] p,
                               input logic [2:0] n);
    exp_t x;
    x.letter = l; x.error = e; x.pattern = p; x.length = n;
    sbq.push_back(x);
  endtask

  // Hold key at v for n sampled clock edges.
  task automatic seg(input logic v, input int n);
    bus.key = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference transmitter: dot 1 unit, dash 3 units, 1-unit intra gap, long trailing low.
  task automatic tx_letter(input logic [2:0] sw);
    logic [3:0] p;
    int n;
    case (sw)
      3'd0: begin p = 4'b0001; n = 2; end
      3'd1: begin p = 4'b1000; n = 4; end
      3'd2: begin p = 4'b1010; n = 4; end
      3'd3: begin p = 4'b0100; n = 3; end
      3'd4: begin p = 4'b0000; n = 1; end
      3'd5: begin p = 4'b0010; n = 4; end
      3'd6: begin p = 4'b0110; n = 3; end
      default: begin p = 4'b0000; n = 4; end
    endcase
    for (int i = n - 1; i >= 0; i--) begin
      seg(1'b1, p[i] ? 12 : 4);
      if (i > 0) seg(1'b0, 4);
    end
    seg(1'b0, 16);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"},   bus.valid,   0);
    check({tag, "_letter"},  bus.letter,  0);
    check({tag, "_error"},   bus.error,   0);
    check({tag, "_pattern"}, bus.pattern, 0);
    check({tag, "_length"},  bus.length,  0);
    check({tag, "_busy"},    bus.busy,    0);
  endtask

  // Monitor
  initial begin
    logic prev_valid;
    exp_t x;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.valid) begin
        check("valid_one_cycle", prev_valid, 0);
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual letter=%0d pattern=%b length=%0d required no valid at %0t",
                   bus.letter, bus.pattern, bus.length, $time);
        end else begin
          x = sbq.pop_front();
          check("letter",  bus.letter,  x.letter);
          check("error",   bus.error,   x.error);
          check("pattern", bus.pattern, x.pattern);
          check("length",  bus.length,  x.length);
          check("busy_at_valid", bus.busy, 0);
        end
      end
      prev_valid = bus.valid;
    end
  end

  // Stimulus
  initial begin
    reset   = 1'b1;
    bus.key = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // A
    expect_letter(3'b000, 1'b0, 4'b0001, 3'd2);
    seg(1, 4); seg(0, 4); seg(1, 12); seg(0, 16);

    // H then E
    expect_letter(3'b111, 1'b0, 4'b0000, 3'd4);
    expect_letter(3'b100, 1'b0, 4'b0000, 3'd1);
    seg(1, 4); seg(0, 4); seg(1, 4); seg(0, 4); seg(1, 4); seg(0, 4); seg(1, 4);
    seg(0, 16);
    seg(1, 4); seg(0, 16);

    // M (invalid) and five dots (overflow)
    expect_letter(3'b000, 1'b1, 4'b0011, 3'd2);
    seg(1, 12); seg(0, 4); seg(1, 12); seg(0, 16);
    expect_letter(3'b000, 1'b1, 4'b0000, 3'd4);
    for (int i = 0; i < 5; i++) begin
      seg(1, 4);
      seg(0, (i == 4) ? 16 : 4);
    end

    // Dash/dot threshold: 8 -> dash (T, not in set), 7 -> dot, 2 -> dot
    expect_letter(3'b000, 1'b1, 4'b0001, 3'd1);
    seg(1, 8); seg(0, 16);
    expect_letter(3'b100, 1'b0, 4'b0000, 3'd1);
    seg(1, 7); seg(0, 16);
    expect_letter(3'b100, 1'b0, 4'b0000, 3'd1);
    seg(1, 2); seg(0, 16);

    // Glitch in IDLE: busy for one cycle then back to idle, no valid
    seg(1, 1);
    seg(0, 2);
    check("glitch_busy_high", bus.busy, 1);
    seg(0, 14);
    check("glitch_busy_low", bus.busy, 0);

    // Gap of 11 keeps one letter (A); gap of 12 splits into E then T
    expect_letter(3'b000, 1'b0, 4'b0001, 3'd2);
    seg(1, 4); seg(0, 11); seg(1, 12); seg(0, 16);
    expect_letter(3'b100, 1'b0, 4'b0000, 3'd1);
    expect_letter(3'b000, 1'b1, 4'b0001, 3'd1);
    seg(1, 4); seg(0, 12); seg(1, 12); seg(0, 16);

    // Reset mid-letter abandons it; next dot decodes as E
    seg(1, 4); seg(0, 4); seg(1, 4);
    bus.key = 1'b0;
    check("busy_mid_letter", bus.busy, 1);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_outputs_zero("mid_reset");
    end
    @(posedge clk); #1;
    reset = 1'b0;
    seg(0, 16);
    expect_letter(3'b100, 1'b0, 4'b0000, 3'd1);
    seg(1, 4); seg(0, 16);

    // Loopback through reference transmitter
    for (int s = 0; s < 8; s++) begin
      logic [2:0] sw;
      logic [3:0] p;
      logic [2:0] n;
      sw = 3'(s);
      case (sw)
        3'd0: begin p = 4'b0001; n = 3'd2; end
        3'd1: begin p = 4'b1000; n = 3'd4; end
        3'd2: begin p = 4'b1010; n = 3'd4; end
        3'd3: begin p = 4'b0100; n = 3'd3; end
        3'd4: begin p = 4'b0000; n = 3'd1; end
        3'd5: begin p = 4'b0010; n = 3'd4; end
        3'd6: begin p = 4'b0110; n = 3'd3; end
        default: begin p = 4'b0000; n = 3'd4; end
      endcase
      expect_letter(sw, 1'b0, p, n);
      tx_letter(sw);
    end

    seg(0, 8);
    check("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Receive-side companion to the Morse letter transmitter. Samples a single on/off keyed line and measures mark and space durations in clock cycles. Classifies each mark as a dot or a dash and detects the inter-letter gap. Decodes the collected symbols into the same 3-bit letter code the transmitter takes on its switch inputs, so a transmitter LED output can be looped straight back for self-check.

## Interface
- UNIT_CYCLES, 25_000_000: clock cycles per Morse unit (dot length); must be ≥ 4.
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- key  input  1  keyed line (1 = mark/LED on); asynchronous to clk.
- valid  output  1  one-cycle pulse: a letter has been decoded.
- letter  output  3  letter code, held until next valid: 000=A, 001=B, 010=C, 011=D, 100=E, 101=F, 110=G, 111=H.
- error  output  1  held with letter: pattern not in A–H, or more than 4 symbols.
- pattern  output  4  raw symbols, held with letter: 1=dash, 0=dot, right-aligned, first symbol in bit length-1.
- length  output  3  number of symbols captured (0–4), held with letter.
- busy  output  1  high whenever FSM is not IDLE.

## Operation
- key passes through a 2-flop synchronizer → key_s. All durations are counted on key_s.
- Run counter cnt has width $clog2(4*UNIT_CYCLES+1) and saturates at 4*UNIT_CYCLES. Its value is the number of consecutive sampled cycles at the current level, counting the first cycle as 1.
- Internal shift register sym[3:0], count len[2:0] and overflow flag ovf are cleared on entry to IDLE.
- FSM states:
  - IDLE
    - key_s=1 → MARK, cnt=1.
  - MARK
    - key_s=1 → cnt++.
    - key_s=0, cnt < UNIT_CYCLES/2 (glitch): discard the mark; → SPACE with cnt=1 if len>0, else → IDLE.
    - key_s=0, cnt < 2*UNIT_CYCLES: append dot. Otherwise append dash. In both cases → SPACE, cnt=1.
  - SPACE
    - key_s=1 → MARK, cnt=1. This is an intra-letter gap; letter continues.
    - key_s=0 and cnt == 3*UNIT_CYCLES-1: emit the letter, → IDLE.
    - Otherwise cnt++.
- Append rule: sym ← {sym[2:0], s}, len++ when len<4. When len==4, set ovf; sym and len are unchanged.
- Emit: in one registered update, pulse valid=1 and load pattern=sym, length=len.
  - letter = code of matching pattern/length: A(2,01), B(4,1000), C(4,1010), D(3,100), E(1,0), F(4,0010), G(3,110), H(4,0000).
  - error = ovf OR no match. When error=1, letter=000.
- Letter and word gaps are not distinguished. Any space ≥3 units ends the letter, and further low time is spent in IDLE.

## Timing
- Reset values: valid=0, letter=000, error=0, pattern=0000, length=000, busy=0. Synchronizer flops=0, FSM=IDLE, cnt=0.
- Reset asserted mid-letter abandons the letter; no valid is produced. The first mark after reset release starts a fresh letter.
- The key→key_s latency is 2 cycles. Durations are exact in key_s cycles, independent of that latency.
- valid rises on the edge where key_s has been low for 3*UNIT_CYCLES consecutive sampled cycles after the last mark. It is high for exactly 1 cycle.
- Boundary conditions:
  - A mark of exactly 2*UNIT_CYCLES is a dash.
  - A mark of exactly UNIT_CYCLES/2 is a dot.
  - A space of 3*UNIT_CYCLES-1 cycles followed by a mark continues the letter.
- busy falls in the same cycle valid rises, or when a glitch returns the FSM to IDLE.
- A mark still held at cnt saturation remains a dash; it has no timeout.

## Test plan
Use UNIT_CYCLES=4 and drive key in clk-aligned cycles. Every letter ends with key low ≥12 cycles unless stated otherwise.
- A: high 4, low 4, high 12 → valid once; letter=000, pattern=0001, length=2, error=0.
- H then E: four dots with low 4 between; low 16; one 4-cycle mark → two valid pulses. First: letter=111, pattern=0000, length=4. Second: letter=100, length=1.
- Invalid and overflow: two dashes (M) → error=1, letter=000, pattern=0011, length=2. Five dots → error=1, length=4.
- Threshold and glitch:
  - An 8-cycle mark → dash; a 7-cycle mark → dot.
  - A 1-cycle high pulse in IDLE → no valid, busy returns to 0.
  - An 11-cycle low between dots keeps them in one letter; 12 cycles splits them.
- Reset mid-letter: two dots, then reset asserted for 3 cycles → all outputs 0, no valid. A subsequent single dot decodes as E.
- Loopback: connect the transmitter's LED output to key and step through SW=000..111 → each decoded letter equals SW, error=0.
